// File: rtl/sargantana_icache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sargantana_icache_miss_ctrl
// Description : I-cache miss sequencer. Picks a victim way, issues a single
//               line fill, writes the returned line, pulses replay, and walks
//               every set clearing valid bits on a flush request.
// Revision    : 1.0 - initial release
// ============================================================================
module sargantana_icache_miss_ctrl #(
    parameter int N_WAY      = 4,
    parameter int ADDR_WIDTH = 40,
    parameter int SET_WIDTH  = 6
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  lookup_valid_i,
    input  logic [N_WAY-1:0]      cline_hit_i,
    input  logic [N_WAY-1:0]      way_valid_bits_i,
    input  logic [ADDR_WIDTH-1:0] miss_paddr_i,
    input  logic                  flush_i,
    output logic                  ifill_req_valid_o,
    input  logic                  ifill_req_ready_i,
    output logic [ADDR_WIDTH-1:0] ifill_req_addr_o,
    input  logic                  ifill_resp_valid_i,
    input  logic                  ifill_resp_error_i,
    output logic [N_WAY-1:0]      way_we_o,
    output logic [SET_WIDTH-1:0]  set_idx_o,
    output logic                  valid_wdata_o,
    output logic                  replay_o,
    output logic                  fill_error_o,
    output logic                  busy_o
);

    localparam int WAY_BITS = (N_WAY > 1) ? $clog2(N_WAY) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_WRITE  = 3'd3,
        S_REPLAY = 3'd4,
        S_FLUSH  = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [WAY_BITS-1:0]   rr_q, rr_d;
    logic [WAY_BITS-1:0]   victim_q, victim_d;
    logic                  evict_valid_q, evict_valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SET_WIDTH-1:0]  set_q, set_d;
    logic [SET_WIDTH-1:0]  flush_idx_q, flush_idx_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  err_q, err_d;

    logic                  free_found;
    logic [WAY_BITS-1:0]   free_way;
    logic                  miss;

    // Descending scan so the lowest-index invalid way is the one kept.
    always_comb begin
        free_found = 1'b0;
        free_way   = '0;
        for (int i = N_WAY - 1; i >= 0; i--) begin
            if (!way_valid_bits_i[i]) begin
                free_found = 1'b1;
                free_way   = WAY_BITS'(i);
            end
        end
    end

    assign miss = lookup_valid_i && (cline_hit_i == '0);

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        victim_d      = victim_q;
        evict_valid_d = evict_valid_q;
        addr_d        = addr_q;
        set_d         = set_q;
        flush_idx_d   = flush_idx_q;
        flush_pend_d  = flush_pend_q;
        err_d         = err_q;

        ifill_req_valid_o = 1'b0;
        ifill_req_addr_o  = '0;
        way_we_o          = '0;
        set_idx_o         = '0;
        valid_wdata_o     = 1'b0;
        replay_o          = 1'b0;
        fill_error_o      = 1'b0;
        busy_o            = (state_q != S_IDLE);

        // A flush arriving mid-miss is remembered and serviced once the miss retires.
        if (flush_i && (state_q != S_IDLE) && (state_q != S_FLUSH)) begin
            flush_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (flush_i) begin
                    flush_idx_d = '0;
                    state_d     = S_FLUSH;
                end else if (miss) begin
                    addr_d        = miss_paddr_i;
                    set_d         = miss_paddr_i[SET_WIDTH-1:0];
                    victim_d      = free_found ? free_way : rr_q;
                    evict_valid_d = !free_found;
                    state_d       = S_REQ;
                end
            end
            S_REQ: begin
                ifill_req_valid_o = 1'b1;
                ifill_req_addr_o  = addr_q;
                if (ifill_req_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ifill_resp_valid_i) begin
                    if (ifill_resp_error_i) begin
                        err_d   = 1'b1;
                        state_d = S_REPLAY;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (flush_pend_q) begin
                    flush_pend_d = 1'b0;
                    flush_idx_d  = '0;
                    state_d      = S_FLUSH;
                end else begin
                    way_we_o      = {{(N_WAY-1){1'b0}}, 1'b1} << victim_q;
                    set_idx_o     = set_q;
                    valid_wdata_o = 1'b1;
                    if (evict_valid_q) begin
                        rr_d = rr_q + WAY_BITS'(1);
                    end
                    state_d = S_REPLAY;
                end
            end
            S_REPLAY: begin
                replay_o     = 1'b1;
                fill_error_o = err_q;
                err_d        = 1'b0;
                if (flush_pend_q) begin
                    flush_pend_d = 1'b0;
                    flush_idx_d  = '0;
                    state_d      = S_FLUSH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                way_we_o    = '1;
                set_idx_o   = flush_idx_q;
                flush_idx_d = flush_idx_q + SET_WIDTH'(1);
                if (flush_idx_q == '1) begin
                    state_d = S_REPLAY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q       <= S_IDLE;
            rr_q          <= '0;
            victim_q      <= '0;
            evict_valid_q <= 1'b0;
            addr_q        <= '0;
            set_q         <= '0;
            flush_idx_q   <= '0;
            flush_pend_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            victim_q      <= victim_d;
            evict_valid_q <= evict_valid_d;
            addr_q        <= addr_d;
            set_q         <= set_d;
            flush_idx_q   <= flush_idx_d;
            flush_pend_q  <= flush_pend_d;
            err_q         <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sargantana_icache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sargantana_icache_miss_ctrl
// Description : Scoreboard bench for the I-cache miss controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sargantana_icache_miss_ctrl;

    localparam logic [1:0] K_REQ = 2'd0;
    localparam logic [1:0] K_WR  = 2'd1;
    localparam logic [1:0] K_RP  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [63:0] data;
    } ev_t;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        lookup_valid_i;
    logic [3:0]  cline_hit_i;
    logic [3:0]  way_valid_bits_i;
    logic [39:0] miss_paddr_i;
    logic        flush_i;
    logic        ifill_req_valid_o;
    logic        ifill_req_ready_i;
    logic [39:0] ifill_req_addr_o;
    logic        ifill_resp_valid_i;
    logic        ifill_resp_error_i;
    logic [3:0]  way_we_o;
    logic [5:0]  set_idx_o;
    logic        valid_wdata_o;
    logic        replay_o;
    logic        fill_error_o;
    logic        busy_o;

    int  vecs = 0;
    int  miscompares = 0;
    ev_t exp_q[$];

    sargantana_icache_miss_ctrl #(.N_WAY(4), .ADDR_WIDTH(40), .SET_WIDTH(6)) dut (
        .clk_i             (clk_i),
        .rstn_i            (rstn_i),
        .lookup_valid_i    (lookup_valid_i),
        .cline_hit_i       (cline_hit_i),
        .way_valid_bits_i  (way_valid_bits_i),
        .miss_paddr_i      (miss_paddr_i),
        .flush_i           (flush_i),
        .ifill_req_valid_o (ifill_req_valid_o),
        .ifill_req_ready_i (ifill_req_ready_i),
        .ifill_req_addr_o  (ifill_req_addr_o),
        .ifill_resp_valid_i(ifill_resp_valid_i),
        .ifill_resp_error_i(ifill_resp_error_i),
        .way_we_o          (way_we_o),
        .set_idx_o         (set_idx_o),
        .valid_wdata_o     (valid_wdata_o),
        .replay_o          (replay_o),
        .fill_error_o      (fill_error_o),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [63:0] wr(input logic [3:0] we, input logic [5:0] s, input logic v);
        return {53'd0, we, s, v};
    endfunction

    task automatic push(input logic [1:0] k, input logic [63:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        vecs++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic check_ev(input logic [1:0] k, input logic [63:0] d, input string nm);
        ev_t e;
        vecs++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s unexpected at %0t: got %h, required no event", nm, $time, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data != d) begin
                miscompares++;
                $display("FAIL %s at %0t: got kind %0d data %h, required kind %0d data %h",
                         nm, $time, k, d, e.kind, e.data);
            end
        end
    endtask

    // Monitor: every observable DUT event is matched against the expectation queue.
    initial begin
        forever begin
            @(negedge clk_i);
            if (ifill_req_valid_o && ifill_req_ready_i) check_ev(K_REQ, {24'd0, ifill_req_addr_o}, "req");
            if (way_we_o != 4'b0) check_ev(K_WR, wr(way_we_o, set_idx_o, valid_wdata_o), "write");
            if (replay_o || fill_error_o) check_ev(K_RP, {62'd0, replay_o, fill_error_o}, "replay");
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy_o && n < bound) begin
            tick();
            n++;
        end
        chk("idle_timeout", {63'd0, busy_o}, 64'd0);
    endtask

    task automatic lookup(input logic [3:0] hit, input logic [3:0] valid, input logic [39:0] a);
        lookup_valid_i   = 1'b1;
        cline_hit_i      = hit;
        way_valid_bits_i = valid;
        miss_paddr_i     = a;
        tick();
        lookup_valid_i   = 1'b0;
    endtask

    task automatic resp(input logic err);
        ifill_resp_valid_i = 1'b1;
        ifill_resp_error_i = err;
        tick();
        ifill_resp_valid_i = 1'b0;
        ifill_resp_error_i = 1'b0;
    endtask

    task automatic miss(input logic [3:0] valid, input logic [39:0] a, input logic [3:0] exp_we,
                        input int lat, input logic err);
        push(K_REQ, {24'd0, a});
        if (!err) push(K_WR, wr(exp_we, a[5:0], 1'b1));
        push(K_RP, {62'd0, 1'b1, err});
        lookup(4'b0000, valid, a);
        repeat (lat) tick();
        resp(err);
        wait_idle(20);
    endtask

    task automatic push_flush();
        for (int i = 0; i < 64; i++) push(K_WR, wr(4'b1111, 6'(i), 1'b0));
        push(K_RP, 64'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] a;
        rstn_i = 1'b0;
        lookup_valid_i = 1'b0; cline_hit_i = '0; way_valid_bits_i = '0; miss_paddr_i = '0;
        flush_i = 1'b0; ifill_req_ready_i = 1'b1; ifill_resp_valid_i = 1'b0; ifill_resp_error_i = 1'b0;
        repeat (3) tick();
        @(negedge clk_i);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_req", {63'd0, ifill_req_valid_o}, 64'd0);
        chk("rst_we", {60'd0, way_we_o}, 64'd0);
        chk("rst_replay", {63'd0, replay_o}, 64'd0);
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        tick();

        // Miss into an all-invalid set, with cycle-exact write/replay timing.
        a = 40'hAB_CDEF_0105;
        push(K_REQ, {24'd0, a});
        push(K_WR, wr(4'b0001, 6'd5, 1'b1));
        push(K_RP, 64'd2);
        lookup(4'b0000, 4'b0000, a);
        repeat (5) tick();
        resp(1'b0);
        @(negedge clk_i);
        chk("lat_we", {60'd0, way_we_o}, 64'd1);
        chk("lat_set", {58'd0, set_idx_o}, 64'd5);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("lat_replay", {63'd0, replay_o}, 64'd1);
        @(posedge clk_i); #1;
        wait_idle(20);

        // Round-robin eviction across a full set, wrap, then a free-way pick.
        miss(4'b1111, 40'h00_0000_1001, 4'b0001, 2, 1'b0);
        miss(4'b1111, 40'h00_0000_1002, 4'b0010, 3, 1'b0);
        miss(4'b1111, 40'h00_0000_1003, 4'b0100, 1, 1'b0);
        miss(4'b1111, 40'h00_0000_1004, 4'b1000, 4, 1'b0);
        miss(4'b1111, 40'h00_0000_1005, 4'b0001, 2, 1'b0);
        miss(4'b1011, 40'h00_0000_1006, 4'b0100, 2, 1'b0);
        miss(4'b1111, 40'h00_0000_1007, 4'b0010, 2, 1'b0);

        // Request held off by ready for 10 cycles.
        a = 40'h12_3456_789A;
        ifill_req_ready_i = 1'b0;
        push(K_REQ, {24'd0, a});
        push(K_WR, wr(4'b0010, a[5:0], 1'b1));
        push(K_RP, 64'd2);
        lookup(4'b0000, 4'b0001, a);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk("stall_valid", {63'd0, ifill_req_valid_o}, 64'd1);
            chk("stall_addr", {24'd0, ifill_req_addr_o}, {24'd0, a});
            @(posedge clk_i); #1;
        end
        ifill_req_ready_i = 1'b1;
        repeat (2) tick();
        resp(1'b0);
        wait_idle(20);

        // Flush during WAIT drops the fill and walks all sets.
        a = 40'h00_0000_2007;
        push(K_REQ, {24'd0, a});
        push_flush();
        lookup(4'b0000, 4'b0000, a);
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        resp(1'b0);
        wait_idle(100);

        // Bus error: no write, replay with fill_error.
        miss(4'b0000, 40'h00_0000_3003, 4'b0000, 3, 1'b1);

        // Hits (single and multiple) issue nothing.
        lookup(4'b0100, 4'b1111, 40'h00_0000_4004);
        @(negedge clk_i);
        chk("hit_busy", {63'd0, busy_o}, 64'd0);
        @(posedge clk_i); #1;
        lookup(4'b0110, 4'b1111, 40'h00_0000_4005);
        @(negedge clk_i);
        chk("multihit_busy", {63'd0, busy_o}, 64'd0);
        @(posedge clk_i); #1;

        // Flush and miss in the same cycle: flush wins.
        push_flush();
        flush_i = 1'b1;
        lookup(4'b0000, 4'b0000, 40'h00_0000_5005);
        flush_i = 1'b0;
        wait_idle(100);

        // Reset in WAIT aborts; a late response is ignored.
        a = 40'h00_0000_6006;
        push(K_REQ, {24'd0, a});
        lookup(4'b0000, 4'b0000, a);
        tick();
        rstn_i = 1'b0;
        tick();
        @(negedge clk_i);
        chk("abort_busy", {63'd0, busy_o}, 64'd0);
        chk("abort_req", {63'd0, ifill_req_valid_o}, 64'd0);
        chk("abort_addr", {24'd0, ifill_req_addr_o}, 64'd0);
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        resp(1'b0);
        repeat (3) tick();
        chk("late_resp_busy", {63'd0, busy_o}, 64'd0);

        repeat (3) tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
